// File: rtl/serial_word_sequencer.sv
// Frames serial bits into an external shift register and holds each word for a valid/ready consumer.
// Optional SHIFT-state watchdog is compiled in with SWS_WATCHDOG_EN.
module serial_word_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SDV,
  input  logic             SYNC,
  output logic             SR_CE,
  input  logic [WIDTH-1:0] SR_Q,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             OVR,
  output logic             FERR,
  output logic             TOUT,
  input  logic             CLR,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (WIDTH < 2) begin : g_width_chk
    $error("WIDTH must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic frame_go;
  logic abort;
  logic cap_load;
  logic ovr_set;
  logic ferr_set;
  logic accept;

  assign frame_go = SDV & SYNC;
  assign accept   = DVALID & DREADY;
  assign BUSY     = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    SR_CE    = 1'b0;
    cap_load = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        SR_CE = frame_go;
        if (frame_go) begin
          state_nx = SHIFT;
          cnt_nx   = ONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          SR_CE = SDV;
          if (frame_go) begin
            ferr_set = 1'b1;
            cnt_nx   = ONE;
          end else if (SDV) begin
            if (cnt == LAST) begin
              state_nx = CAPTURE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
      end
      CAPTURE: begin
        // SR_Q is sampled before any shift caused by a new frame's first bit
        cap_load = ~DVALID | DREADY;
        ovr_set  = DVALID & ~DREADY;
        SR_CE    = frame_go;
        if (frame_go) begin
          state_nx = SHIFT;
          cnt_nx   = ONE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (!RSTN) begin
      SR_CE = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
    end else if (cap_load) begin
      DOUT   <= SR_Q;
      DVALID <= 1'b1;
    end else if (accept) begin
      DVALID <= 1'b0;
    end
  end

  // A set in the same cycle as CLR wins
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OVR  <= 1'b0;
      FERR <= 1'b0;
    end else begin
      OVR  <= ovr_set | (OVR & ~CLR);
      FERR <= ferr_set | (FERR & ~CLR);
    end
  end

`ifdef SWS_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle;

  assign abort = (state == SHIFT) & ~SDV & (idle == IDLE_MAX);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idle <= '0;
    end else if ((state != SHIFT) || SDV || abort) begin
      idle <= '0;
    end else begin
      idle <= idle + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      TOUT <= 1'b0;
    end else begin
      TOUT <= abort | (TOUT & ~CLR);
    end
  end
`else
  assign abort = 1'b0;
  assign TOUT  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_sequencer.sv
// Bench for serial_word_sequencer: external shift register model plus a bit-queue reference.
// Directed scenarios followed by randomized traffic.
module tb_serial_word_sequencer;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic         SDV = 1'b0;
  logic         SYNC = 1'b0;
  logic         DREADY = 1'b0;
  logic         CLR = 1'b0;
  logic         SR_CE;
  logic [W-1:0] SR_Q;
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         OVR;
  logic         FERR;
  logic         TOUT;
  logic         BUSY;
  logic         d = 1'b0;
  logic [W-1:0] sr = '0;

  int total = 0;
  int bad = 0;

  // reference model state
  bit           m_active;
  bit           m_cap;
  bit           q[$];
  int           m_idle;
  logic [W-1:0] m_dout;
  bit           m_dvalid;
  bit           m_ovr;
  bit           m_ferr;
  bit           m_tout;
  bit           exp_ce;
  logic         obs_ce;
  int           ce_obs_hi;
  int           ce_exp_hi;
  logic [W-1:0] acc[$];

  serial_word_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .SDV(SDV), .SYNC(SYNC),
    .SR_CE(SR_CE), .SR_Q(SR_Q), .DOUT(DOUT), .DVALID(DVALID),
    .DREADY(DREADY), .OVR(OVR), .FERR(FERR), .TOUT(TOUT),
    .CLR(CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (SR_CE) sr <= {sr[W-2:0], d};
  end
  assign SR_Q = sr;

  always @(posedge CLK) begin
    if (RSTN && DVALID && DREADY) acc.push_back(DOUT);
  end

  function automatic bit m_busy();
    return m_active || m_cap;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_cap = 0; q.delete(); m_idle = 0;
    m_dout = '0; m_dvalid = 0; m_ovr = 0; m_ferr = 0; m_tout = 0;
  endfunction

  function automatic void model_step(bit sdv, bit sync, bit b, bit dr, bit clr);
    bit n_ovr, n_ferr, n_tout;
    logic [W-1:0] word;
    n_ovr = 0; n_ferr = 0; n_tout = 0;
    if (m_cap) begin
      word = '0;
      foreach (q[i]) word[W-1-i] = q[i];
      if (!m_dvalid || dr) begin
        m_dout = word;
        m_dvalid = 1;
      end else begin
        n_ovr = 1;
      end
      m_cap = 0;
      q.delete();
    end else if (m_dvalid && dr) begin
      m_dvalid = 0;
    end
    if (sdv && sync) begin
      if (m_active) n_ferr = 1;
      q.delete();
      q.push_back(b);
      m_active = 1;
      m_idle = 0;
    end else if (m_active && sdv) begin
      q.push_back(b);
      m_idle = 0;
      if (q.size() == W) begin
        m_active = 0;
        m_cap = 1;
      end
    end else if (m_active) begin
`ifdef SWS_WATCHDOG_EN
      m_idle++;
      if (m_idle == TO) begin
        m_active = 0;
        q.delete();
        m_idle = 0;
        n_tout = 1;
      end
`endif
    end
    m_ovr  = n_ovr  || (m_ovr  && !clr);
    m_ferr = n_ferr || (m_ferr && !clr);
    m_tout = n_tout || (m_tout && !clr);
  endfunction

  task automatic tick(input bit sdv, input bit sync, input bit b,
                      input bit dr, input bit clr);
    SDV = sdv; SYNC = sync; d = b; DREADY = dr; CLR = clr;
    #2;
    exp_ce = (m_active && !m_cap) ? sdv : (sdv && sync);
    obs_ce = SR_CE;
    if (obs_ce === 1'b1) ce_obs_hi++;
    if (exp_ce) ce_exp_hi++;
    model_step(sdv, sync, b, dr, clr);
    @(posedge CLK);
    #1;
    SDV = 0; SYNC = 0; CLR = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit dr);
    for (int i = 0; i < W; i++) tick(1, i == 0, w[W-1-i], dr, 0);
  endtask

  task automatic test_reset();
    SDV = 1; SYNC = 1;
    #2;
    total++;
    if (SR_CE !== 1'b0) begin
      bad++; $display("FAIL reset_ce got=%b exp=0", SR_CE);
    end
    total++;
    if ({DOUT, DVALID, OVR, FERR, TOUT, BUSY} !== '0) begin
      bad++;
      $display("FAIL reset_out got=%h/%b%b%b%b%b exp=0", DOUT, DVALID, OVR, FERR, TOUT, BUSY);
    end
    @(negedge CLK);
    SDV = 0; SYNC = 0; RSTN = 1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    ce_obs_hi = 0; ce_exp_hi = 0;
    send_word(8'hA5, 0);
    total++;
    if (DVALID !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL basic_capture_cycle got dv=%b busy=%b exp dv=0 busy=1", DVALID, BUSY);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (DVALID !== 1'b1 || DOUT !== 8'hA5) begin
      bad++; $display("FAIL basic_word got dv=%b dout=%h exp dv=1 dout=a5", DVALID, DOUT);
    end
    total++;
    if (ce_obs_hi != 8 || ce_obs_hi != ce_exp_hi) begin
      bad++; $display("FAIL basic_ce_count got=%0d exp=8 model=%0d", ce_obs_hi, ce_exp_hi);
    end
    tick(0, 0, 0, 1, 0);
    total++;
    if (DVALID !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL basic_accept got dv=%b busy=%b exp 0 0", DVALID, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    acc.delete();
    send_word(8'hA5, 1);
    send_word(8'h3C, 1);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    total++;
    if (acc.size() != 2) begin
      bad++; $display("FAIL b2b_count got=%0d exp=2", acc.size());
    end else begin
      total++;
      if (acc[0] !== 8'hA5 || acc[1] !== 8'h3C) begin
        bad++; $display("FAIL b2b_words got=%h,%h exp=a5,3c", acc[0], acc[1]);
      end
    end
    total++;
    if (OVR !== 1'b0) begin
      bad++; $display("FAIL b2b_ovr got=%b exp=0", OVR);
    end
  endtask

  task automatic test_overrun();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    tick(0, 0, 0, 0, 0);
    total++;
    if (DOUT !== 8'hA5 || DVALID !== 1'b1 || OVR !== 1'b1) begin
      bad++; $display("FAIL ovr_set got dout=%h dv=%b ovr=%b exp a5 1 1", DOUT, DVALID, OVR);
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (OVR !== 1'b0 || DOUT !== 8'hA5) begin
      bad++; $display("FAIL ovr_clr got ovr=%b dout=%h exp 0 a5", OVR, DOUT);
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_ferr();
    for (int i = 0; i < 4; i++) tick(1, i == 0, 1'($urandom_range(0, 1)), 1, 0);
    send_word(8'h96, 1);
    total++;
    if (FERR !== 1'b1) begin
      bad++; $display("FAIL ferr_set got=%b exp=1", FERR);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (DOUT !== 8'h96 || DVALID !== 1'b1) begin
      bad++; $display("FAIL ferr_word got dout=%h dv=%b exp 96 1", DOUT, DVALID);
    end
    tick(0, 0, 0, 1, 1);
    total++;
    if (FERR !== 1'b0) begin
      bad++; $display("FAIL ferr_clr got=%b exp=0", FERR);
    end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 3; i++) tick(1, i == 0, 1, 0, 0);
`ifdef SWS_WATCHDOG_EN
    for (int i = 0; i < TO - 1; i++) tick(0, 0, 0, 0, 0);
    total++;
    if (TOUT !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL wdog_early got tout=%b busy=%b exp 0 1", TOUT, BUSY);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (TOUT !== 1'b1 || BUSY !== 1'b0 || DVALID !== 1'b0) begin
      bad++; $display("FAIL wdog_fire got tout=%b busy=%b dv=%b exp 1 0 0", TOUT, BUSY, DVALID);
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (TOUT !== 1'b0) begin
      bad++; $display("FAIL wdog_clr got=%b exp=0", TOUT);
    end
`else
    for (int i = 0; i < TO + 4; i++) tick(0, 0, 0, 0, 0);
    total++;
    if (TOUT !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL nowdog_wait got tout=%b busy=%b exp 0 1", TOUT, BUSY);
    end
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    total++;
    if (DOUT !== 8'hE7 || DVALID !== 1'b1) begin
      bad++; $display("FAIL nowdog_word got dout=%h dv=%b exp e7 1", DOUT, DVALID);
    end
    tick(0, 0, 0, 1, 0);
`endif
  endtask

  task automatic test_reset_midframe();
    send_word(8'h5A, 0);
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, i == 0, 1, 0, 0);
    RSTN = 0; SDV = 1; SYNC = 1;
    #2;
    total++;
    if ({DOUT, DVALID, OVR, FERR, TOUT, BUSY, SR_CE} !== '0) begin
      bad++;
      $display("FAIL rst_mid got dout=%h dv=%b busy=%b ce=%b exp all 0", DOUT, DVALID, BUSY, SR_CE);
    end
    model_reset();
    @(negedge CLK);
    SDV = 0; SYNC = 0; RSTN = 1;
    @(posedge CLK);
    #1;
    send_word(8'hC3, 1);
    tick(0, 0, 0, 0, 0);
    total++;
    if (DOUT !== 8'hC3 || DVALID !== 1'b1) begin
      bad++; $display("FAIL rst_mid_word got dout=%h dv=%b exp c3 1", DOUT, DVALID);
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit sdv, sync, b, dr, clr;
    for (int n = 0; n < 600; n++) begin
      sdv  = ($urandom_range(0, 9) < 6);
      sync = ($urandom_range(0, 11) == 0);
      b    = 1'($urandom_range(0, 1));
      dr   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      tick(sdv, sync, b, dr, clr);
      total++;
      if (obs_ce !== exp_ce) begin
        bad++; $display("FAIL rand_ce cyc=%0d got=%b exp=%b", n, obs_ce, exp_ce);
      end
      total++;
      if ({DVALID, DOUT, OVR, FERR, TOUT, BUSY} !==
          {m_dvalid, m_dout, m_ovr, m_ferr, m_tout, m_busy()}) begin
        bad++;
        $display("FAIL rand_out cyc=%0d got dv=%b dout=%h o=%b f=%b t=%b b=%b exp dv=%b dout=%h o=%b f=%b t=%b b=%b",
                 n, DVALID, DOUT, OVR, FERR, TOUT, BUSY,
                 m_dvalid, m_dout, m_ovr, m_ferr, m_tout, m_busy());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_ferr();
    test_watchdog();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
